// File: rtl/reg_write_arbiter_if.sv
// Requester-side handshake bundle for reg_write_arbiter.
// Valid/ready: a requester holds valid, addr and data steady until it sees
// ready high. The transfer happens on the posedge where valid && ready.
// Addresses and data are packed per requester, with requester 0 in the LSBs.
interface reg_write_arbiter_if #(
    parameter int NREQ = 3,
    parameter int DW   = 16,
    parameter int AW   = 3
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    modport master (output req_valid, output req_addr, output req_data, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/reg_write_arbiter.sv
// Shares the single write port of the register file among NREQ requesters.
// Each requester has a one-entry slot. A round-robin scheduler drains the
// slots into a registered rd/busD_in/r_latch stage. A per-register busy mask
// blocks a second write to a register until the first has left the output
// stage, which keeps same-register writes in acceptance order.
module reg_write_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 16,
    parameter int AW   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg_write_arbiter_if.slave    req,
    input  logic                  freeze,
    output logic [AW-1:0]         rd,
    output logic [DW-1:0]         busD_in,
    output logic                  r_latch,
    output logic [(1<<AW)-1:0]    busy
);
    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] slot_v;
    logic [AW-1:0]   slot_addr [NREQ];
    logic [DW-1:0]   slot_data [NREQ];
    logic [RW-1:0]   rr;

    logic [NREQ-1:0] ready;
    logic [NREQ-1:0] accept;
    logic            any_valid;
    logic            issue;
    logic [RW-1:0]   winner;
    logic [RW-1:0]   rr_next;

    // Pending-write mask: every full slot plus the write currently on the port.
    always_comb begin
        busy = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (slot_v[i]) busy[slot_addr[i]] = 1'b1;
        end
        if (r_latch) busy[rd] = 1'b1;
    end

    // Ready per requester; on an address tie the lower index wins, and nothing is ready in reset.
    always_comb begin : ready_calc
        logic [NREQ-1:0] rdy;
        logic            conflict;
        rdy      = '0;
        conflict = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            conflict = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (req.req_valid[j] && rdy[j] &&
                    (req.req_addr[j*AW +: AW] == req.req_addr[i*AW +: AW]))
                    conflict = 1'b1;
            end
            rdy[i] = rst_n && !slot_v[i] && !busy[req.req_addr[i*AW +: AW]] && !conflict;
        end
        ready = rdy;
    end

    assign req.req_ready = ready;
    assign accept        = req.req_valid & ready;

    // Round-robin pick: the lowest valid slot at or above rr, else the lowest valid slot overall.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (slot_v[i]) begin
                any_valid = 1'b1;
                winner    = RW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (slot_v[i] && (RW'(i) >= rr)) winner = RW'(i);
        end
        issue   = any_valid && !freeze;
        rr_next = (winner == RW'(NREQ - 1)) ? '0 : winner + RW'(1);
    end

    // Slot fill/drain, output stage and round-robin pointer. Reset drops all pending writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_v  <= '0;
            rr      <= '0;
            rd      <= '0;
            busD_in <= '0;
            r_latch <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                slot_addr[i] <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            // A slot that is full cannot accept, so accept and issue never hit the same slot.
            for (int i = 0; i < NREQ; i++) begin
                if (accept[i]) begin
                    slot_v[i]    <= 1'b1;
                    slot_addr[i] <= req.req_addr[i*AW +: AW];
                    slot_data[i] <= req.req_data[i*DW +: DW];
                end else if (issue && (winner == RW'(i))) begin
                    slot_v[i] <= 1'b0;
                end
            end
            if (issue) begin
                rd      <= slot_addr[winner];
                busD_in <= slot_data[winner];
                r_latch <= 1'b1;
                rr      <= rr_next;
            end else begin
                r_latch <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter. Accepted writes are queued in their
// predicted issue order. A negedge monitor pops the queue on each r_latch,
// checks the write, and applies it to a model register file.
module tb_reg_write_arbiter;
    localparam int NREQ = 3;
    localparam int DW   = 16;
    localparam int AW   = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          freeze;
    logic [AW-1:0] rd;
    logic [DW-1:0] busD_in;
    logic          r_latch;
    logic [7:0]    busy;

    reg_write_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) ifc ();

    reg_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (ifc),
        .freeze  (freeze),
        .rd      (rd),
        .busD_in (busD_in),
        .r_latch (r_latch),
        .busy    (busy)
    );

    // Clock and reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    rf_model [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ifc.req_valid[i]          = 1'b1;
        ifc.req_addr[i*AW +: AW]  = a;
        ifc.req_data[i*DW +: DW]  = d;
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // Scoreboard: the register file latches on negedge
    always @(negedge clk) begin
        if (rst_n === 1'b1 && r_latch === 1'b1) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL spurious_write: observed rd=%0d data=0x%0h expected no write", rd, busD_in);
            end
            if (exp_q.size() > 0) check("write_order", {13'd0, rd, busD_in}, {13'd0, exp_q.pop_front()});
            rf_model[rd] = busD_in;
        end
    end

    initial begin
        logic [DW-1:0] d [3];
        for (int r = 0; r < 8; r++) rf_model[r] = '0;
        rst_n         = 1'b0;
        freeze        = 1'b0;
        ifc.req_valid = '0;
        ifc.req_addr  = '0;
        ifc.req_data  = '0;

        // Reset with all requesters offering distinct addresses
        offer(0, 3'd1, 16'h0001);
        offer(1, 3'd2, 16'h0002);
        offer(2, 3'd3, 16'h0003);
        repeat (3) tick();
        check("rst_ready", {29'd0, ifc.req_ready}, 32'h0);
        check("rst_r_latch", {31'd0, r_latch}, 32'h0);
        check("rst_rd", {29'd0, rd}, 32'h0);
        check("rst_busD_in", {16'd0, busD_in}, 32'h0);
        check("rst_busy", {24'd0, busy}, 32'h0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {29'd0, ifc.req_ready}, 32'h7);
        ifc.req_valid = '0;

        // Single write: req0 addr 5 data BEEF
        tick();
        offer(0, 3'd5, 16'hBEEF);
        #1;
        check("single_ready", {31'd0, ifc.req_ready[0]}, 32'h1);
        push_exp(3'd5, 16'hBEEF);
        tick();
        ifc.req_valid = '0;
        check("single_busy_slot", {24'd0, busy}, 32'h20);
        check("single_no_issue_yet", {31'd0, r_latch}, 32'h0);
        tick();
        check("single_r_latch", {31'd0, r_latch}, 32'h1);
        check("single_rd", {29'd0, rd}, 32'h5);
        check("single_data", {16'd0, busD_in}, 32'hBEEF);
        check("single_busy_out", {24'd0, busy}, 32'h20);
        tick();
        check("single_busy_clear", {24'd0, busy}, 32'h0);
        check("single_r_latch_drop", {31'd0, r_latch}, 32'h0);
        check("single_rf5", {16'd0, rf_model[5]}, 32'hBEEF);

        // Write through req2 so the pointer wraps back to 0
        offer(2, 3'd6, 16'h1234);
        push_exp(3'd6, 16'h1234);
        tick();
        ifc.req_valid = '0;
        tick();
        check("req2_rd", {29'd0, rd}, 32'h6);
        tick();

        // Round-robin: all three offer addresses 1,2,3, then again after draining
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 3; i++) begin
                d[i] = 16'($urandom_range(0, 65535));
                offer(i, AW'(i + 1), d[i]);
            end
            #1;
            check("rr_ready", {29'd0, ifc.req_ready}, 32'h7);
            for (int i = 0; i < 3; i++) push_exp(AW'(i + 1), d[i]);
            tick();
            ifc.req_valid = '0;
            for (int i = 0; i < 3; i++) begin
                tick();
                check("rr_r_latch", {31'd0, r_latch}, 32'h1);
                check("rr_rd", {29'd0, rd}, i + 1);
            end
            tick();
            check("rr_idle", {31'd0, r_latch}, 32'h0);
        end

        // Same-address tie: req0 and req2 both target addr 4
        offer(0, 3'd4, 16'h4444);
        offer(2, 3'd4, 16'h5555);
        #1;
        check("tie_ready0", {31'd0, ifc.req_ready[0]}, 32'h1);
        check("tie_ready2", {31'd0, ifc.req_ready[2]}, 32'h0);
        push_exp(3'd4, 16'h4444);
        tick();
        ifc.req_valid[0] = 1'b0;
        #1;
        check("tie_ready2_slot_busy", {31'd0, ifc.req_ready[2]}, 32'h0);
        tick();
        check("tie_ready2_out_busy", {31'd0, ifc.req_ready[2]}, 32'h0);
        check("tie_first_data", {16'd0, busD_in}, 32'h4444);
        tick();
        check("tie_ready2_free", {31'd0, ifc.req_ready[2]}, 32'h1);
        push_exp(3'd4, 16'h5555);
        tick();
        ifc.req_valid = '0;
        tick();
        check("tie_second_r_latch", {31'd0, r_latch}, 32'h1);
        check("tie_second_data", {16'd0, busD_in}, 32'h5555);
        tick();
        check("tie_rf4", {16'd0, rf_model[4]}, 32'h5555);

        // Freeze with two slots full; a third request still gets in
        offer(0, 3'd1, 16'h1111);
        offer(1, 3'd2, 16'h2222);
        freeze = 1'b1;
        #1;
        check("frz_ready01", {30'd0, ifc.req_ready[1:0]}, 32'h3);
        tick();
        ifc.req_valid = '0;
        offer(2, 3'd3, 16'h3333);
        #1;
        check("frz_busy_a", {24'd0, busy}, 32'h06);
        check("frz_r_latch_a", {31'd0, r_latch}, 32'h0);
        check("frz_ready2", {31'd0, ifc.req_ready[2]}, 32'h1);
        tick();
        ifc.req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            check("frz_busy", {24'd0, busy}, 32'h0E);
            check("frz_r_latch", {31'd0, r_latch}, 32'h0);
            if (c < 2) tick();
        end
        push_exp(3'd1, 16'h1111);
        push_exp(3'd2, 16'h2222);
        push_exp(3'd3, 16'h3333);
        freeze = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("unfrz_r_latch", {31'd0, r_latch}, 32'h1);
            check("unfrz_rd", {29'd0, rd}, i + 1);
        end
        tick();
        check("unfrz_busy_clear", {24'd0, busy}, 32'h0);

        // Reset while a write is on the port and two slots are full
        offer(0, 3'd1, 16'hDEAD);
        offer(1, 3'd2, 16'hDEAD);
        offer(2, 3'd3, 16'hDEAD);
        tick();
        ifc.req_valid = '0;
        tick();
        check("mid_r_latch", {31'd0, r_latch}, 32'h1);
        check("mid_busy", {24'd0, busy}, 32'h0E);
        rst_n = 1'b0;
        #1;
        check("mid_rst_r_latch", {31'd0, r_latch}, 32'h0);
        check("mid_rst_busy", {24'd0, busy}, 32'h0);
        check("mid_rst_rd", {29'd0, rd}, 32'h0);
        check("mid_rst_ready", {29'd0, ifc.req_ready}, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("rel_busy", {24'd0, busy}, 32'h0);
        check("rel_ready", {29'd0, ifc.req_ready}, 32'h7);
        repeat (3) tick();
        check("rel_no_write", {31'd0, r_latch}, 32'h0);

        // Final register file contents and drained queue
        check("rf1", {16'd0, rf_model[1]}, 32'h1111);
        check("rf2", {16'd0, rf_model[2]}, 32'h2222);
        check("rf3", {16'd0, rf_model[3]}, 32'h3333);
        check("rf4", {16'd0, rf_model[4]}, 32'h5555);
        check("rf5", {16'd0, rf_model[5]}, 32'hBEEF);
        check("rf6", {16'd0, rf_model[6]}, 32'h1234);
        check("exp_q_empty", exp_q.size(), 32'h0);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
